// File: rtl/ask_demod_if.sv
// Signal bundle between the ASK demodulator and its driver: sample/control
// inputs plus the decided-bit outputs.
interface ask_demod_if #(
    parameter int mpr = 14,
    parameter int spw = 8
);
    localparam int accw = mpr - 1 + spw;

    logic                   clken;
    logic signed [mpr-1:0]  din;
    logic                   run_en;
    logic [spw-1:0]         sps;
    logic [accw-1:0]        thr;
    logic [mpr-2:0]         sq_lvl;
    logic                   bit_o;
    logic                   out_valid;
    logic                   locked;

    modport master (
        output clken, din, run_en, sps, thr, sq_lvl,
        input  bit_o, out_valid, locked
    );

    modport slave (
        input  clken, din, run_en, sps, thr, sq_lvl,
        output bit_o, out_valid, locked
    );
endinterface

// File: rtl/ask_demod_id.sv
// Integrate-and-dump ASK demodulator: rectifies samples, sums one symbol,
// compares against a threshold and drops lock after 8 consecutive zero bits.
module ask_demod_id #(
    parameter int mpr = 14,
    parameter int spw = 8
) (
    input  logic        clk,
    input  logic        reset,
    ask_demod_if.slave  bus
);
    localparam int accw = mpr - 1 + spw;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [mpr-2:0]   mag, mag_nxt, din_neg;
    logic [accw-1:0]  acc, acc_nxt, sum;
    logic [spw-1:0]   cnt, cnt_nxt, sps_l, sps_l_nxt, sps_clamped;
    logic [2:0]       miss_cnt, miss_nxt;
    logic             bit_r, bit_nxt, valid_r, valid_nxt;
    logic             decision;

    // Rectifier; the most negative code has no positive twin, so it saturates.
    always_comb begin
        din_neg = ~bus.din[mpr-2:0] + (mpr-1)'(1);
        mag_nxt = mag;
        if (bus.clken) begin
            if (!bus.din[mpr-1])
                mag_nxt = bus.din[mpr-2:0];
            else if (bus.din[mpr-2:0] == '0)
                mag_nxt = '1;
            else
                mag_nxt = din_neg;
        end
    end

    assign sum         = acc + accw'(mag);
    assign decision    = (sum > bus.thr);
    assign sps_clamped = (bus.sps < spw'(2)) ? spw'(2) : bus.sps;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Dropping run_en aborts immediately, even between sample enables.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sps_l_nxt = sps_l;
        miss_nxt  = miss_cnt;
        bit_nxt   = bit_r;
        valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                acc_nxt  = '0;
                cnt_nxt  = '0;
                miss_nxt = '0;
                if (bus.clken && bus.run_en && (mag > bus.sq_lvl)) begin
                    state_nxt = RUN;
                    acc_nxt   = accw'(mag);
                    cnt_nxt   = spw'(1);
                    sps_l_nxt = sps_clamped;
                end
            end
            RUN: begin
                if (!bus.run_en) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    miss_nxt  = '0;
                end else if (bus.clken) begin
                    if (cnt == sps_l - spw'(1)) begin
                        bit_nxt   = decision;
                        valid_nxt = 1'b1;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        sps_l_nxt = sps_clamped;
                        if (decision) begin
                            miss_nxt = '0;
                        end else if (miss_cnt == 3'd7) begin
                            miss_nxt  = '0;
                            state_nxt = IDLE;
                        end else begin
                            miss_nxt = miss_cnt + 3'd1;
                        end
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + spw'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag      <= '0;
            acc      <= '0;
            cnt      <= '0;
            sps_l    <= '0;
            miss_cnt <= '0;
            bit_r    <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            mag      <= mag_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            sps_l    <= sps_l_nxt;
            miss_cnt <= miss_nxt;
            bit_r    <= bit_nxt;
            valid_r  <= valid_nxt;
        end
    end

    assign bus.bit_o     = bit_r;
    assign bus.out_valid = valid_r;
    assign bus.locked    = (state == RUN);
endmodule

// File: tb/tb_ask_demod_id.sv
// Directed bench for ask_demod_id: lock, decisions, thresholds, loss of lock,
// gated clken and mid-symbol disturbances, with hand-computed expectations.
module tb_ask_demod_id;
    localparam int mpr  = 14;
    localparam int spw  = 8;
    localparam int accw = mpr - 1 + spw;

    logic clk = 1'b0;
    logic reset;

    ask_demod_if #(.mpr(mpr), .spw(spw)) bus ();

    ask_demod_id #(.mpr(mpr), .spw(spw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   n;
    int   k;
    int   zeros;
    int   pulses;
    logic seen;
    logic s;
    logic prev;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic signed [mpr-1:0] d, input logic en,
                                  input logic [spw-1:0] sp, input logic [accw-1:0] t,
                                  input logic ce);
        bus.din    = d;
        bus.run_en = en;
        bus.sps    = sp;
        bus.thr    = t;
        bus.clken  = ce;
    endtask

    // Outputs must clear while reset is high, before any clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        check_output({tag, "_bit"},    {31'd0, bus.bit_o},     32'd0);
        check_output({tag, "_valid"},  {31'd0, bus.out_valid}, 32'd0);
        check_output({tag, "_locked"}, {31'd0, bus.locked},    32'd0);
        step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, output int cnt_o, output logic seen_o);
        cnt_o  = 0;
        seen_o = 1'b0;
        while (cnt_o < max_cyc && !seen_o) begin
            step();
            cnt_o++;
            if (bus.out_valid) seen_o = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.sq_lvl = 13'd1000;
        apply_stimulus(14'sd0, 1'b0, 8'd16, 21'd40000, 1'b1);
        #1;
        do_reset("rst0");

        // Constant +4000: lock, first decision 17 edges in, then every 16.
        apply_stimulus(14'sd4000, 1'b1, 8'd16, 21'd40000, 1'b1);
        wait_valid(40, n, seen);
        check_output("a_seen", {31'd0, seen}, 32'd1);
        check_output("a_latency", n, 32'd17);
        check_output("a_bit", {31'd0, bus.bit_o}, 32'd1);
        check_output("a_locked", {31'd0, bus.locked}, 32'd1);
        step();
        check_output("a_width", {31'd0, bus.out_valid}, 32'd0);
        wait_valid(40, n, seen);
        check_output("a_spacing", n + 1, 32'd16);
        check_output("a_bit2", {31'd0, bus.bit_o}, 32'd1);

        // Most negative input saturates to 8191; 16*8191 = 131056 sits on the threshold.
        do_reset("rst1");
        apply_stimulus(14'h2000, 1'b1, 8'd16, 21'd40000, 1'b1);
        wait_valid(40, n, seen);
        check_output("b_latency", n, 32'd17);
        check_output("b_bit", {31'd0, bus.bit_o}, 32'd1);
        bus.thr = 21'd131056;
        wait_valid(40, n, seen);
        check_output("b_eq_thr", {31'd0, bus.bit_o}, 32'd0);
        bus.thr = 21'd131055;
        wait_valid(40, n, seen);
        check_output("b_above_thr", {31'd0, bus.bit_o}, 32'd1);

        // sps below 2 behaves as 2: sum of two samples is 8000.
        do_reset("rst2");
        apply_stimulus(14'sd4000, 1'b1, 8'd0, 21'd7999, 1'b1);
        wait_valid(10, n, seen);
        check_output("m_latency", n, 32'd3);
        check_output("m_bit", {31'd0, bus.bit_o}, 32'd1);
        wait_valid(10, n, seen);
        check_output("m_spacing", n, 32'd2);
        bus.thr = 21'd8000;
        wait_valid(10, n, seen);
        check_output("m_bit_eq", {31'd0, bus.bit_o}, 32'd0);

        // Alternating 4000/1000 symbols aligned to lock -> 1,0,1,0.
        do_reset("rst3");
        apply_stimulus(14'sd4000, 1'b1, 8'd16, 21'd40000, 1'b1);
        k = 0;
        for (int i = 1; i <= 68; i++) begin
            bus.din = ((((i - 1) / 16) % 2) == 0) ? 14'sd4000 : 14'sd1000;
            step();
            if (bus.out_valid) begin
                check_output("c_edge", i, 32'(17 + 16 * k));
                check_output("c_bit", {31'd0, bus.bit_o}, ((k % 2) == 0) ? 32'd1 : 32'd0);
                k++;
            end
        end
        check_output("c_count", k, 32'd4);

        // Weak +-200 signal after lock: eight zero symbols, then unlock.
        do_reset("rst4");
        apply_stimulus(14'sd4000, 1'b1, 8'd16, 21'd40000, 1'b1);
        wait_valid(40, n, seen);
        check_output("d_lock_bit", {31'd0, bus.bit_o}, 32'd1);
        zeros = 0;
        n = 0;
        s = 1'b1;
        while (zeros < 8 && n < 200) begin
            bus.din = s ? 14'sd200 : -14'sd200;
            s = ~s;
            step();
            n++;
            if (bus.out_valid) begin
                check_output("d_bit", {31'd0, bus.bit_o}, 32'd0);
                zeros++;
                if (zeros < 8) check_output("d_still_locked", {31'd0, bus.locked}, 32'd1);
            end
        end
        check_output("d_zeros", zeros, 32'd8);
        check_output("d_span", n, 32'd128);
        check_output("d_unlocked", {31'd0, bus.locked}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            bus.din = s ? 14'sd200 : -14'sd200;
            s = ~s;
            step();
            if (bus.out_valid) pulses++;
            if (bus.locked) pulses++;
        end
        check_output("d_quiet", pulses, 32'd0);

        // clken one clk in three: pulses every 48 clk, each one clk wide.
        do_reset("rst5");
        apply_stimulus(14'sd4000, 1'b1, 8'd16, 21'd40000, 1'b0);
        k = 0;
        prev = 1'b0;
        for (int j = 0; j < 150; j++) begin
            bus.clken = ((j % 3) == 0);
            step();
            if (prev) check_output("e_width", {31'd0, bus.out_valid}, 32'd0);
            if (bus.out_valid) begin
                check_output("e_edge", j, 32'(48 * (k + 1)));
                check_output("e_bit", {31'd0, bus.bit_o}, 32'd1);
                k++;
            end
            prev = bus.out_valid;
        end
        check_output("e_count", k, 32'd3);

        // Reset in the middle of a symbol.
        do_reset("rst6");
        apply_stimulus(14'sd4000, 1'b1, 8'd16, 21'd40000, 1'b1);
        wait_valid(40, n, seen);
        repeat (7) step();
        check_output("f1_pre_bit", {31'd0, bus.bit_o}, 32'd1);
        check_output("f1_pre_locked", {31'd0, bus.locked}, 32'd1);
        do_reset("f1_rst");

        // run_en drop mid-symbol with clken low still aborts on the next edge.
        apply_stimulus(14'sd4000, 1'b1, 8'd16, 21'd40000, 1'b1);
        wait_valid(40, n, seen);
        check_output("f2_bit", {31'd0, bus.bit_o}, 32'd1);
        repeat (7) step();
        bus.run_en = 1'b0;
        bus.clken  = 1'b0;
        step();
        check_output("f2_unlocked", {31'd0, bus.locked}, 32'd0);
        bus.clken = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.out_valid) pulses++;
        end
        check_output("f2_no_valid", pulses, 32'd0);
        check_output("f2_bit_hold", {31'd0, bus.bit_o}, 32'd1);

        // sps change mid-symbol only takes effect from the next symbol.
        do_reset("rst7");
        apply_stimulus(14'sd4000, 1'b1, 8'd16, 21'd40000, 1'b1);
        wait_valid(40, n, seen);
        check_output("f3_latency", n, 32'd17);
        repeat (7) step();
        bus.sps = 8'd8;
        wait_valid(40, n, seen);
        check_output("f3_cur_len", n + 7, 32'd16);
        check_output("f3_cur_bit", {31'd0, bus.bit_o}, 32'd1);
        wait_valid(40, n, seen);
        check_output("f3_next_len", n, 32'd8);
        check_output("f3_next_bit", {31'd0, bus.bit_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ask_demod_id.md
ASK_DEMOD_ID -- requirements
Module: ask_demod_id

Interface
REQ-001 Parameter mpr, default 14: sample width, two's complement; matches the NCO/modulator output width.
REQ-002 Parameter spw, default 8: symbol-counter width; accw = mpr-1+spw is the accumulator width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clken  input  1  sample enable; all sample processing advances only on edges where clken=1.
REQ-006 din  input  mpr  received ASK sample, signed.
REQ-007 run_en  input  1  demodulator enable.
REQ-008 sps  input  spw  samples per symbol; values below 2 treated as 2.
REQ-009 thr  input  accw  decision threshold, unsigned.
REQ-010 sq_lvl  input  mpr-1  squelch magnitude, unsigned.
REQ-011 bit_o  output  1  decided symbol bit.
REQ-012 out_valid  output  1  one-clk pulse qualifying bit_o.
REQ-013 locked  output  1  high while in RUN state.

Function
REQ-014 Magnitude stage: on clken edge, mag <= |din|; the most negative input saturates to 2^(mpr-1)-1; mag is unsigned, width mpr-1.
REQ-015 FSM states: IDLE, RUN; state, acc, cnt and miss_cnt change only on clken edges, except as given in REQ-020 and REQ-021.
REQ-016 IDLE: acc=0, cnt=0, locked=0; on a clken edge with run_en=1 and mag>sq_lvl, go to RUN, load acc<=mag, cnt<=1, and latch sps into sps_l.
REQ-017 RUN, on each clken edge: acc<=acc+mag, cnt<=cnt+1.
REQ-018 Symbol dump: on the clken edge where cnt==sps_l-1 (the sps_l-th sample), the block SHALL do all of the following:
- bit_o <= ((acc+mag) > thr);
- acc<=0, cnt<=0;
- re-latch sps_l from sps.
REQ-019 out_valid SHALL be high for exactly one clk cycle, the cycle after the dump edge, independent of the clken value in that cycle; bit_o holds until the next dump.
REQ-020 Loss of lock: miss_cnt (3 bits) increments on each dump with decided bit 0 and clears on decided bit 1. When a zero decision would make the count 8, that symbol is still output, then the FSM returns to IDLE and miss_cnt clears.
REQ-021 run_en=0 in RUN: on the next clk edge, regardless of clken, go to IDLE; the partial symbol is discarded with no out_valid.
REQ-022 Arithmetic: acc width is accw, unsigned, and cannot overflow because sps_l <= 2^spw-1; the comparison is strict greater-than, full width.
REQ-023 Latency: din sample at clken edge k reaches mag at k; the last sample of a symbol is accumulated at the dump edge, which is the next clken edge; out_valid follows that dump edge by 1 clk.
REQ-024 A change of sps mid-symbol SHALL NOT affect the current symbol.

Reset
REQ-025 While reset=1, asynchronously and without waiting for a clock edge:
- state=IDLE;
- mag, acc, cnt, miss_cnt, sps_l = 0;
- bit_o=0, out_valid=0, locked=0.
REQ-026 After reset deasserts, the first clken edge SHALL be treated as a normal IDLE cycle.

Verification
REQ-027 Parameters mpr=14, spw=8; inputs sps=16, thr=40000, sq_lvl=1000, clken=1; din=+4000 constant -> locked=1; bit_o=1 (acc 64000) with an out_valid pulse every 16 cycles.
REQ-028 din=-8192 constant -> mag=8191; per-symbol sum 131056, no wrap; bit_o=1.
REQ-029 Alternating symbols, amplitude 4000 then 1000 (sum 16000), 16 samples each, aligned to lock -> bits 1,0,1,0.
REQ-030 After lock, din=+-200 -> 8 zero symbols output, then locked=0; no further out_valid; din stays below sq_lvl -> remains IDLE.
REQ-031 clken high 1 of every 3 clk cycles, din=4000 -> same decisions; each out_valid exactly 1 clk wide, spaced 48 clk.
REQ-032 Disturbances mid-symbol:
- reset pulse at cnt=7 -> all outputs 0 immediately;
- run_en=0 at cnt=7 -> IDLE next edge with no out_valid;
- sps changed to 8 at cnt=7 -> current symbol still 16 samples, next symbol 8.
